// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone single-write master.
// Request bundle, FSM states and the config slave base address.
package wb_master_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2
    } wb_state_e;

    localparam logic [31:0] CFG_SLAVE_ADDR = 32'hb000_0000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Request FIFO of wb_req_t; full/empty are registered so the
// producer-facing ready has no path from the pop side.
module wb_req_fifo
    import wb_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    p_clk,
    input  logic    p_resetn,
    input  logic    push,
    input  wb_req_t wdata,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge p_clk) begin
        if (!p_resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge p_clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/wb_write_master.sv
// Wishbone B3 single-write master: queues requests and issues each as
// one classic write cycle with retry, error and timeout handling.
module wb_write_master
    import wb_master_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic        p_clk,
    input  logic        p_resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_sel,
    output logic [31:0] p_wb_ADR_O,
    output logic [31:0] p_wb_DAT_O,
    input  logic [31:0] p_wb_DAT_I,
    output logic [3:0]  p_wb_SEL_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_STB_O,
    output logic        p_wb_WE_O,
    output logic        p_wb_LOCK_O,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I,
    input  logic        p_wb_RTY_I,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;

    wb_state_e      state;
    wb_state_e      state_nxt;
    wb_req_t        head;
    wb_req_t        wdata;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           launch;
    logic           ok;
    logic           drop;
    logic           retry_ok;
    logic           tmo_hit;
    logic [TW-1:0]  tmo_cnt;
    logic [RW-1:0]  retry_cnt;
    logic           dat_i_unused;

    assign dat_i_unused = ^p_wb_DAT_I;

    assign req_ready   = !full;
    assign push        = req_valid && !full;
    assign wdata       = '{addr: req_addr, data: req_data, sel: req_sel};
    assign pop         = ok || drop;
    assign busy        = !empty || (state != IDLE);
    assign p_wb_LOCK_O = 1'b0;
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));
    assign retry_ok    = (retry_cnt < RW'(MAX_RETRY));

    wb_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .p_clk    (p_clk),
        .p_resetn (p_resetn),
        .push     (push),
        .wdata    (wdata),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    always_ff @(posedge p_clk) begin
        if (!p_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response priority is ERR > RTY > ACK; silence counts toward timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!empty) state_nxt = BUS;
            end
            BUS: begin
                if (p_wb_ERR_I) begin
                    state_nxt = IDLE;
                end else if (p_wb_RTY_I) begin
                    state_nxt = retry_ok ? GAP : IDLE;
                end else if (p_wb_ACK_I || tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                state_nxt = BUS;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        launch = 1'b0;
        ok     = 1'b0;
        drop   = 1'b0;
        unique case (state)
            IDLE: begin
                launch = !empty;
            end
            BUS: begin
                if (p_wb_ERR_I) begin
                    drop = 1'b1;
                end else if (p_wb_RTY_I) begin
                    drop = !retry_ok;
                end else if (p_wb_ACK_I) begin
                    ok = 1'b1;
                end else begin
                    drop = tmo_hit;
                end
            end
            GAP: begin
                launch = 1'b1;
            end
            default: begin
                launch = 1'b0;
            end
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (!p_resetn) begin
            p_wb_ADR_O <= '0;
            p_wb_DAT_O <= '0;
            p_wb_SEL_O <= '0;
            p_wb_CYC_O <= 1'b0;
            p_wb_STB_O <= 1'b0;
            p_wb_WE_O  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
        end else begin
            p_wb_CYC_O <= (state_nxt == BUS);
            p_wb_STB_O <= (state_nxt == BUS);
            p_wb_WE_O  <= (state_nxt == BUS);
            if (launch) begin
                p_wb_ADR_O <= head.addr;
                p_wb_DAT_O <= head.data;
                p_wb_SEL_O <= head.sel;
            end
            done <= ok;
            err  <= drop;
            if (drop) err_count <= sat_inc8(err_count);
            if (pop) begin
                retry_cnt <= '0;
            end else if (state == BUS && p_wb_RTY_I && !p_wb_ERR_I) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            if (launch) begin
                tmo_cnt <= '0;
            end else if (state == BUS && state_nxt == BUS) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_write_master.sv
// Randomised and directed bench for wb_write_master against a
// transaction-level queue model.
module tb_wb_write_master;
    import wb_master_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int MAXR  = 3;

    localparam int R_ACK    = 1;
    localparam int R_ERR    = 2;
    localparam int R_RTY    = 3;
    localparam int R_ERRACK = 4;

    localparam int M_ACK    = 0;
    localparam int M_STALL  = 1;
    localparam int M_SCRIPT = 2;
    localparam int M_RAND   = 3;
    localparam int M_ERR    = 4;

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_sel = '0;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_O;
    logic [31:0] p_wb_DAT_I = 32'hdead_beef;
    logic [3:0]  p_wb_SEL_O;
    logic        p_wb_CYC_O;
    logic        p_wb_STB_O;
    logic        p_wb_WE_O;
    logic        p_wb_LOCK_O;
    logic        p_wb_ACK_I = 1'b0;
    logic        p_wb_ERR_I = 1'b0;
    logic        p_wb_RTY_I = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    wb_write_master #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO),
        .MAX_RETRY  (MAXR)
    ) dut (
        .p_clk       (p_clk),
        .p_resetn    (p_resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_sel     (req_sel),
        .p_wb_ADR_O  (p_wb_ADR_O),
        .p_wb_DAT_O  (p_wb_DAT_O),
        .p_wb_DAT_I  (p_wb_DAT_I),
        .p_wb_SEL_O  (p_wb_SEL_O),
        .p_wb_CYC_O  (p_wb_CYC_O),
        .p_wb_STB_O  (p_wb_STB_O),
        .p_wb_WE_O   (p_wb_WE_O),
        .p_wb_LOCK_O (p_wb_LOCK_O),
        .p_wb_ACK_I  (p_wb_ACK_I),
        .p_wb_ERR_I  (p_wb_ERR_I),
        .p_wb_RTY_I  (p_wb_RTY_I),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 p_clk = ~p_clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the queue holds every accepted request not yet completed.
    wb_req_t mq[$];
    bit      m_stb = 1'b0;
    int      m_tries = 0;
    int      m_wait = 0;
    bit      m_done = 1'b0;
    bit      m_err = 1'b0;
    int      m_errcnt = 0;

    int      mode = M_ACK;
    int      script[$];
    bit      rand_req = 1'b0;

    int          n_done = 0;
    int          n_err = 0;
    int          n_rise = 0;
    int          n_stbcyc = 0;
    bit          prev_stb = 1'b0;
    logic [31:0] rise_adr[$];

    task automatic model_update();
        bit can_push;
        bit fin;
        bit drp;
        wb_req_t r;
        if (!p_resetn) begin
            mq.delete();
            m_stb = 0; m_tries = 0; m_wait = 0;
            m_done = 0; m_err = 0; m_errcnt = 0;
            return;
        end
        can_push = (mq.size() < DEPTH);
        m_done = 0;
        m_err = 0;
        fin = 0;
        drp = 0;
        if (m_stb) begin
            if (p_wb_ERR_I) begin
                drp = 1;
            end else if (p_wb_RTY_I) begin
                if (m_tries == MAXR) drp = 1;
                else begin
                    m_tries++;
                    m_stb = 0;
                end
            end else if (p_wb_ACK_I) begin
                fin = 1;
            end else begin
                m_wait++;
                if (m_wait == TMO) drp = 1;
            end
            if (fin || drp) begin
                void'(mq.pop_front());
                m_stb = 0;
                m_tries = 0;
                m_done = fin;
                m_err = drp;
                if (drp && m_errcnt < 255) m_errcnt++;
            end
        end else if (mq.size() > 0) begin
            m_stb = 1;
            m_wait = 0;
        end
        if (req_valid && can_push) begin
            r.addr = req_addr;
            r.data = req_data;
            r.sel  = req_sel;
            mq.push_back(r);
        end
    endtask

    task automatic compare();
        check("cyc", 64'(p_wb_CYC_O), 64'(m_stb));
        check("stb", 64'(p_wb_STB_O), 64'(m_stb));
        check("we", 64'(p_wb_WE_O), 64'(m_stb));
        check("lock", 64'(p_wb_LOCK_O), 64'(0));
        if (m_stb && mq.size() > 0) begin
            check("adr", 64'(p_wb_ADR_O), 64'(mq[0].addr));
            check("dat", 64'(p_wb_DAT_O), 64'(mq[0].data));
            check("sel", 64'(p_wb_SEL_O), 64'(mq[0].sel));
        end
        check("done", 64'(done), 64'(m_done));
        check("err", 64'(err), 64'(m_err));
        check("err_count", 64'(err_count), 64'(m_errcnt));
        check("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
        check("busy", 64'(busy), 64'(mq.size() > 0 || m_stb));
        if (p_wb_STB_O && !prev_stb) begin
            n_rise++;
            rise_adr.push_back(p_wb_ADR_O);
        end
        if (p_wb_STB_O) n_stbcyc++;
        if (done) n_done++;
        if (err) n_err++;
        prev_stb = p_wb_STB_O;
    endtask

    task automatic drive();
        int r;
        p_wb_ACK_I = 0;
        p_wb_ERR_I = 0;
        p_wb_RTY_I = 0;
        r = 0;
        case (mode)
            M_ACK:   p_wb_ACK_I = p_wb_STB_O;
            M_ERR:   p_wb_ERR_I = p_wb_STB_O;
            M_SCRIPT: if (p_wb_STB_O) r = (script.size() > 0) ? script.pop_front() : R_ACK;
            M_RAND: begin
                r = int'($urandom_range(0, 99));
                if (r < 45) r = R_ACK;
                else if (r < 55) r = R_ERR;
                else if (r < 67) r = R_RTY;
                else if (r < 71) r = R_ERRACK;
                else if (r < 74) begin
                    p_wb_ACK_I = 1;
                    r = R_RTY;
                end else r = 0;
            end
            default: r = 0;
        endcase
        if (r == R_ACK) p_wb_ACK_I = 1;
        if (r == R_ERR || r == R_ERRACK) p_wb_ERR_I = 1;
        if (r == R_ERRACK) p_wb_ACK_I = 1;
        if (r == R_RTY) p_wb_RTY_I = 1;
        if (rand_req) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = CFG_SLAVE_ADDR | ($urandom & 32'h0000_0ffc);
            req_data  = $urandom;
            req_sel   = 4'($urandom);
        end
    endtask

    task automatic step();
        @(posedge p_clk);
        model_update();
        @(negedge p_clk);
        compare();
        drive();
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        req_valid = 1;
        req_addr = a;
        req_data = d;
        req_sel = s;
        step();
        req_valid = 0;
    endtask

    task automatic clear_obs();
        n_done = 0;
        n_err = 0;
        n_rise = 0;
        n_stbcyc = 0;
        rise_adr.delete();
    endtask

    initial begin
        p_resetn = 0;
        repeat (2) step();
        p_resetn = 1;
        check("rst_cyc", 64'(p_wb_CYC_O), 64'(0));
        check("rst_adr", 64'(p_wb_ADR_O), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        check("rst_errcnt", 64'(err_count), 64'(0));

        // single zero-wait write
        mode = M_ACK;
        clear_obs();
        push_req(CFG_SLAVE_ADDR, 32'h1234_5678, 4'hf);
        check("lat_e_stb", 64'(p_wb_STB_O), 64'(0));
        step();
        check("lat_e1_stb", 64'(p_wb_STB_O), 64'(1));
        check("lat_e1_adr", 64'(p_wb_ADR_O), 64'h0000_0000_b000_0000);
        check("lat_e1_dat", 64'(p_wb_DAT_O), 64'h0000_0000_1234_5678);
        step();
        check("lat_e2_stb", 64'(p_wb_STB_O), 64'(0));
        check("lat_e2_done", 64'(done), 64'(1));
        step();
        check("single_done_cnt", 64'(n_done), 64'(1));
        check("single_stb_cyc", 64'(n_stbcyc), 64'(1));

        // fill while the slave stalls, then release
        mode = M_STALL;
        clear_obs();
        for (int i = 0; i < 4; i++) push_req(CFG_SLAVE_ADDR + 32'(4 * i), 32'(i), 4'hf);
        check("full_ready", 64'(req_ready), 64'(0));
        mode = M_ACK;
        repeat (20) step();
        check("fill_done_cnt", 64'(n_done), 64'(4));
        check("fill_rise_cnt", 64'(n_rise), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < rise_adr.size())
                check("fill_order", 64'(rise_adr[i]), 64'(CFG_SLAVE_ADDR + 32'(4 * i)));
        end

        // two retries then ACK
        mode = M_SCRIPT;
        script = '{R_RTY, R_RTY, R_ACK};
        clear_obs();
        push_req(CFG_SLAVE_ADDR + 32'h20, 32'haaaa_5555, 4'h3);
        repeat (15) step();
        check("rty2_rise", 64'(n_rise), 64'(3));
        check("rty2_done", 64'(n_done), 64'(1));
        check("rty2_err", 64'(n_err), 64'(0));
        if (rise_adr.size() == 3)
            check("rty2_adr", 64'(rise_adr[2]), 64'(CFG_SLAVE_ADDR + 32'h20));

        // retry exhaustion
        script = '{R_RTY, R_RTY, R_RTY, R_RTY};
        clear_obs();
        push_req(CFG_SLAVE_ADDR + 32'h24, 32'h0bad_f00d, 4'hc);
        repeat (20) step();
        check("rty4_rise", 64'(n_rise), 64'(4));
        check("rty4_err", 64'(n_err), 64'(1));
        check("rty4_done", 64'(n_done), 64'(0));
        check("rty4_errcnt", 64'(err_count), 64'(1));

        // ERR and ACK together, then a clean request
        script = '{R_ERRACK};
        clear_obs();
        push_req(CFG_SLAVE_ADDR + 32'h28, 32'h1, 4'h1);
        push_req(CFG_SLAVE_ADDR + 32'h2c, 32'h2, 4'h2);
        repeat (15) step();
        check("erack_err", 64'(n_err), 64'(1));
        check("erack_done", 64'(n_done), 64'(1));
        check("erack_errcnt", 64'(err_count), 64'(2));

        // timeout
        mode = M_STALL;
        clear_obs();
        push_req(CFG_SLAVE_ADDR + 32'h30, 32'h3, 4'hf);
        repeat (25) step();
        check("tmo_stb_cyc", 64'(n_stbcyc), 64'(16));
        check("tmo_err", 64'(n_err), 64'(1));
        check("tmo_errcnt", 64'(err_count), 64'(3));

        // error saturation
        mode = M_ERR;
        for (int i = 0; i < 560; i++) begin
            req_valid = 1;
            req_addr = CFG_SLAVE_ADDR + 32'(4 * i);
            req_data = 32'(i);
            req_sel = 4'hf;
            step();
        end
        req_valid = 0;
        repeat (12) step();
        check("sat_errcnt", 64'(err_count), 64'(255));

        // reset while a strobe is out with three entries queued
        mode = M_STALL;
        for (int i = 0; i < 4; i++) push_req(CFG_SLAVE_ADDR + 32'(16 * i), 32'hc0de_0000 + 32'(i), 4'hf);
        check("mid_stb", 64'(p_wb_STB_O), 64'(1));
        clear_obs();
        p_resetn = 0;
        step();
        p_resetn = 1;
        check("mid_cyc", 64'(p_wb_CYC_O), 64'(0));
        check("mid_stb0", 64'(p_wb_STB_O), 64'(0));
        check("mid_we", 64'(p_wb_WE_O), 64'(0));
        check("mid_adr", 64'(p_wb_ADR_O), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_errcnt", 64'(err_count), 64'(0));
        mode = M_ACK;
        push_req(CFG_SLAVE_ADDR, 32'h5a5a_5a5a, 4'hf);
        repeat (6) step();
        check("mid_done", 64'(n_done), 64'(1));
        check("mid_err", 64'(n_err), 64'(0));

        // random traffic with occasional resets
        mode = M_RAND;
        rand_req = 1;
        for (int i = 0; i < 4000; i++) begin
            p_resetn = ($urandom_range(0, 599) != 0);
            step();
        end
        p_resetn = 1;
        rand_req = 0;
        req_valid = 0;
        mode = M_ACK;
        repeat (40) step();
        check("drain_busy", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
